baud_gen_frac: RTL
==================

// Module: baud_gen_frac
// PURPOSE
//  Runtime-programmable fractional baud generator for the UART TX/RX datapaths.
//  Emits an oversample tick (8x or 16x), a bit tick and a mid-bit tick.
//  The average sample period is div_int + div_frac/2^FRAC_W clocks.
//  Divisor changes are glitch-free (applied on interval boundaries).
//  sync_clear re-phases the generator on start-bit detection.
// PARAMETERS
//  DIV_W        16  width of integer divisor
//  FRAC_W       4   width of fractional divisor / phase accumulator
//  DEF_DIV_INT  27  active integer divisor after reset (50 MHz, 115200 baud, 16x)
//  DEF_DIV_FRAC 2   active fractional divisor after reset
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  enable       in   1       run; 0 = held idle
//  load         in   1       1-cycle strobe: capture div_int/div_frac/osr_sel
//  div_int      in   DIV_W   integer divisor, legal 1..2^DIV_W-1
//  div_frac     in   FRAC_W  fractional divisor, in 1/2^FRAC_W units
//  osr_sel      in   1       0 = 16x oversample, 1 = 8x oversample
//  sync_clear   in   1       re-phase counters (receiver start-bit align)
//  sample_tick  out  1       1-cycle pulse per oversample interval
//  bit_tick     out  1       1-cycle pulse per bit; coincident with the OSR-th sample_tick
//  mid_tick     out  1       1-cycle pulse coincident with the (OSR/2)-th sample_tick
//  cfg_pending  out  1       loaded config waiting for the next boundary
//  cfg_err      out  1       active div_int == 0; generator stalled
// BEHAVIOUR
//  - Reset: all outputs 0.
//    - Active config = {DEF_DIV_INT, DEF_DIV_FRAC, 16x}; pending config cleared.
//    - cnt, acc and osr_cnt are 0.
//  - Priority per edge: reset > !enable > sync_clear > normal run.
//  - Period: period = div_int + carry(acc + div_frac), using active values and the current acc.
//  - Normal run, each edge:
//    - cnt != period-1: cnt++, all ticks 0.
//    - cnt == period-1 (boundary): cnt <= 0; acc <= (acc + div_frac) mod 2^FRAC_W; sample_tick <= 1.
//  - Outputs are registered: the first sample_tick is high in the cycle after the period-th enabled edge.
//    - div_int = 1, div_frac = 0 gives sample_tick high continuously.
//  - osr_cnt (0..OSR-1) increments on each boundary and wraps at OSR-1.
//    - bit_tick <= 1 at the boundary where osr_cnt == OSR-1.
//    - mid_tick <= 1 at the boundary where osr_cnt == OSR/2-1.
//  - Config update (load):
//    - load captures into pending and sets cfg_pending = 1.
//    - Pending is applied at the next boundary, sync_clear or disabled edge; cfg_pending then clears.
//    - A load on a boundary edge is held for the following boundary.
//    - Load while pending overwrites pending.
//    - An osr_sel change resets osr_cnt to 0 when applied.
//  - enable = 0: cnt, acc, osr_cnt <= 0; ticks 0; pending config applied.
//  - sync_clear (enable = 1): cnt, acc, osr_cnt <= 0; ticks 0.
//    - The next sample_tick follows after a full period.
//  - Active div_int == 0: cfg_err = 1; cnt held at 0; no ticks.
//    - Only a load/apply to a nonzero value recovers.
//  - Reset mid-interval: reset wins; the next tick follows full reset timing.
// STRUCTURE
//  - uart_pkg: OSR_16 = 16, OSR_8 = 8, osr_sel encoding, default divisor constants.
//  - Sub-module baud_cfg_shadow: pending/active config registers, cfg_pending, cfg_err.
//  - Top level: cnt, acc and osr_cnt logic, tick registers.
// TESTING
//  1. Reset, enable, defaults:
//     - sample intervals follow a 27,27,...,28 pattern; 2 long intervals per 16 (avg 27.125).
//  2. div_int = 3, div_frac = 8, 16x:
//     - intervals alternate 3,4,3,4.
//     - bit_tick every 56 clocks; mid_tick 28 clocks after bit_tick.
//  3. div_int = 1, div_frac = 0, 8x:
//     - sample_tick high every cycle.
//     - bit_tick every 8 cycles; mid_tick on the 4th sample_tick.
//  4. load div_int = 10 at cnt = 2 of a 27 interval:
//     - cfg_pending = 1 for 24 cycles; that interval stays 27.
//     - The next interval is 10; cfg_pending then returns to 0.
//  5. load div_int = 0:
//     - cfg_err = 1 after apply; no ticks for 100 cycles.
//     - load div_int = 5 with enable low: cfg_err = 0; intervals of 5 after enable.
//  6. sync_clear at osr_cnt = 9, 16x, div_int = 4:
//     - next sample_tick after 4 cycles.
//     - mid_tick 32 cycles, bit_tick 64 cycles after sync_clear.
//     - reset asserted mid-run: all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: oversample ratios, osr_sel encoding and reset divisor defaults.
package uart_pkg;

    localparam int unsigned OSR_16           = 16;
    localparam int unsigned OSR_8            = 8;
    localparam int unsigned OSR_CNT_W        = 4;
    localparam int unsigned DEFAULT_DIV_INT  = 27;
    localparam int unsigned DEFAULT_DIV_FRAC = 2;

    typedef enum logic {
        Osr16 = 1'b0,
        Osr8  = 1'b1
    } osr_sel_e;

    function automatic logic [OSR_CNT_W-1:0] osr_last(input osr_sel_e sel);
        return (sel == Osr8) ? OSR_CNT_W'(OSR_8 - 1) : OSR_CNT_W'(OSR_16 - 1);
    endfunction

    function automatic logic [OSR_CNT_W-1:0] osr_mid(input osr_sel_e sel);
        return (sel == Osr8) ? OSR_CNT_W'(OSR_8 / 2 - 1) : OSR_CNT_W'(OSR_16 / 2 - 1);
    endfunction

endpackage

// File: rtl/baud_cfg_shadow.sv
// Pending/active divisor shadow registers; pending config moves to active on apply.
module baud_cfg_shadow
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned DEF_DIV_INT  = DEFAULT_DIV_INT,
    parameter int unsigned DEF_DIV_FRAC = DEFAULT_DIV_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              apply,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  osr_sel_e          osr_sel,
    output logic [DIV_W-1:0]  act_div_int,
    output logic [FRAC_W-1:0] act_div_frac,
    output osr_sel_e          act_osr_sel,
    output logic              osr_change,
    output logic              cfg_pending,
    output logic              cfg_err
);

    logic [DIV_W-1:0]  pend_int_q, pend_int_d, act_int_q, act_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d, act_frac_q, act_frac_d;
    osr_sel_e          pend_osr_q, pend_osr_d, act_osr_q, act_osr_d;
    logic              pending_q, pending_d;

    // Apply uses the pending value held before this edge; a same-edge load waits for the next one.
    always_comb begin
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_osr_d  = pend_osr_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        act_osr_d   = act_osr_q;
        pending_d   = pending_q;
        if (apply && pending_q) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            act_osr_d  = pend_osr_q;
            pending_d  = 1'b0;
        end
        if (load) begin
            pend_int_d  = div_int;
            pend_frac_d = div_frac;
            pend_osr_d  = osr_sel;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_osr_q  <= Osr16;
            act_int_q   <= DIV_W'(DEF_DIV_INT);
            act_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
            act_osr_q   <= Osr16;
            pending_q   <= 1'b0;
        end else begin
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_osr_q  <= pend_osr_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            act_osr_q   <= act_osr_d;
            pending_q   <= pending_d;
        end
    end

    assign act_div_int  = act_int_q;
    assign act_div_frac = act_frac_q;
    assign act_osr_sel  = act_osr_q;
    assign osr_change   = apply && pending_q && (pend_osr_q != act_osr_q);
    assign cfg_pending  = pending_q;
    assign cfg_err      = (act_int_q == '0);

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: sample, mid-bit and bit ticks from an integer+fraction divisor.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned DEF_DIV_INT  = DEFAULT_DIV_INT,
    parameter int unsigned DEF_DIV_FRAC = DEFAULT_DIV_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              osr_sel,
    input  logic              sync_clear,
    output logic              sample_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              cfg_pending,
    output logic              cfg_err
);

    logic [DIV_W-1:0]     act_div_int;
    logic [FRAC_W-1:0]    act_div_frac;
    osr_sel_e             act_osr_sel;
    logic                 osr_change, apply, boundary, stalled;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [FRAC_W-1:0]    acc_q, acc_d;
    logic [OSR_CNT_W-1:0] osr_cnt_q, osr_cnt_d;
    logic                 sample_d, bit_d, mid_d;
    logic [FRAC_W:0]      acc_sum;
    logic [DIV_W:0]       period;

    baud_cfg_shadow #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .DEF_DIV_INT  (DEF_DIV_INT),
        .DEF_DIV_FRAC (DEF_DIV_FRAC)
    ) u_cfg (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .apply        (apply),
        .div_int      (div_int),
        .div_frac     (div_frac),
        .osr_sel      (osr_sel_e'(osr_sel)),
        .act_div_int  (act_div_int),
        .act_div_frac (act_div_frac),
        .act_osr_sel  (act_osr_sel),
        .osr_change   (osr_change),
        .cfg_pending  (cfg_pending),
        .cfg_err      (cfg_err)
    );

    // Phase accumulator carry stretches this interval by one clock.
    assign acc_sum  = {1'b0, acc_q} + {1'b0, act_div_frac};
    assign period   = {1'b0, act_div_int} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
    assign stalled  = cfg_err;
    assign boundary = enable && !sync_clear && !stalled
                      && ({1'b0, cnt_q} == period - {{DIV_W{1'b0}}, 1'b1});
    // A stalled generator never reaches a boundary, so every enabled edge may apply.
    assign apply    = !enable || sync_clear || stalled || boundary;

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        osr_cnt_d = osr_cnt_q;
        sample_d  = 1'b0;
        bit_d     = 1'b0;
        mid_d     = 1'b0;
        if (!enable || sync_clear) begin
            cnt_d     = '0;
            acc_d     = '0;
            osr_cnt_d = '0;
        end else if (stalled) begin
            cnt_d = '0;
            if (osr_change) osr_cnt_d = '0;
        end else if (boundary) begin
            cnt_d     = '0;
            acc_d     = acc_sum[FRAC_W-1:0];
            sample_d  = 1'b1;
            bit_d     = (osr_cnt_q == osr_last(act_osr_sel));
            mid_d     = (osr_cnt_q == osr_mid(act_osr_sel));
            osr_cnt_d = (osr_change || bit_d) ? '0 : osr_cnt_q + OSR_CNT_W'(1);
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            osr_cnt_q   <= '0;
            sample_tick <= 1'b0;
            bit_tick    <= 1'b0;
            mid_tick    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            osr_cnt_q   <= osr_cnt_d;
            sample_tick <= sample_d;
            bit_tick    <= bit_d;
            mid_tick    <= mid_d;
        end
    end

endmodule
